// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//  Branch condition resolver plus a direct-mapped table of 2-bit saturating
//  counters. The table is looked up at fetch and trained at resolve.
//  The unit also flags mispredictions and keeps saturating statistics.
//
// Ports
//  clk             rising-edge clock
//  rst_n           synchronous active-low reset
//  lookup_valid    fetch lookup request
//  lookup_pc       fetch PC
//  pred_valid      prediction valid, one cycle after lookup_valid
//  pred_taken      predicted direction (MSB of the indexed counter)
//  res_valid       resolve strobe from execute
//  res_pc          PC of the resolving branch
//  res_mode        branch mode: 00 BEQ, 01 BNE, 10 BLEZ, 11 BGTZ
//  res_zero        ALU zero flag
//  res_neg         ALU sign flag
//  res_pred_taken  prediction carried down the pipe with this branch
//  branch_taken    combinational, res_valid & cond
//  mispredict      registered one-cycle pulse, one cycle after res_valid
//  br_count        resolved branch count, saturating
//  mp_count        misprediction count, saturating
module branch_predict_unit #(
  parameter int         PC_W     = 32,
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_valid,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [PC_W-1:0]   res_pc,
  input  logic [1:0]        res_mode,
  input  logic              res_zero,
  input  logic              res_neg,
  input  logic              res_pred_taken,
  output logic              branch_taken,
  output logic              mispredict,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] mp_count
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [1:0]        pht_q [DEPTH];
  logic              pred_valid_q;
  logic              pred_taken_q;
  logic              mispredict_q;
  logic [STAT_W-1:0] br_count_q;
  logic [STAT_W-1:0] mp_count_q;

  logic [IDX_W-1:0]  lookup_idx;
  logic [IDX_W-1:0]  res_idx;
  logic              cond;
  logic              mp_now;
  logic [1:0]        cnt_cur;
  logic [1:0]        cnt_d;
  logic [STAT_W-1:0] br_count_d;
  logic [STAT_W-1:0] mp_count_d;

  // Word-aligned PCs: drop the two byte-offset bits before indexing.
  assign lookup_idx = lookup_pc[IDX_W+1:2];
  assign res_idx    = res_pc[IDX_W+1:2];

  always_comb begin
    cond = 1'b0;
    case (res_mode)
      2'b00:   cond = res_zero;
      2'b01:   cond = ~res_zero;
      2'b10:   cond = res_zero | res_neg;
      default: cond = ~res_zero & ~res_neg;
    endcase
  end

  assign branch_taken = res_valid & cond;
  assign mp_now       = res_valid & (cond != res_pred_taken);

  // Saturating counter step for the entry being trained.
  assign cnt_cur = pht_q[res_idx];
  always_comb begin
    cnt_d = cnt_cur;
    if (cond) begin
      if (cnt_cur != 2'b11) cnt_d = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_d = cnt_cur - 2'b01;
    end
  end

  always_comb begin
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (res_valid && br_count_q != STAT_MAX) br_count_d = br_count_q + 1'b1;
    if (mp_now && mp_count_q != STAT_MAX)    mp_count_d = mp_count_q + 1'b1;
  end

  // The lookup reads pht_q before this edge's update lands, which gives
  // read-before-write when lookup and resolve hit the same entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pht_q[i] <= CNT_INIT;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      mispredict_q <= 1'b0;
      br_count_q   <= '0;
      mp_count_q   <= '0;
    end else begin
      pred_valid_q <= lookup_valid;
      pred_taken_q <= lookup_valid & pht_q[lookup_idx][1];
      if (res_valid) pht_q[res_idx] <= cnt_d;
      mispredict_q <= mp_now;
      br_count_q   <= br_count_d;
      mp_count_q   <= mp_count_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign mispredict = mispredict_q;
  assign br_count   = br_count_q;
  assign mp_count   = mp_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  logic        clk;
  logic        rst_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [1:0]  res_mode;
  logic        res_zero;
  logic        res_neg;
  logic        res_pred_taken;

  logic        pred_valid, pred_taken, branch_taken, mispredict;
  logic [15:0] br_count, mp_count;
  logic        pred_valid4, pred_taken4, branch_taken4, mispredict4;
  logic [3:0]  br_count4, mp_count4;

  int n_checks = 0;
  int n_pass   = 0;

  branch_predict_unit #(.PC_W(32), .IDX_W(4), .CNT_INIT(2'b01), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .res_mode(res_mode),
    .res_zero(res_zero), .res_neg(res_neg), .res_pred_taken(res_pred_taken),
    .branch_taken(branch_taken), .mispredict(mispredict),
    .br_count(br_count), .mp_count(mp_count)
  );

  branch_predict_unit #(.PC_W(32), .IDX_W(4), .CNT_INIT(2'b01), .STAT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid4), .pred_taken(pred_taken4),
    .res_valid(res_valid), .res_pc(res_pc), .res_mode(res_mode),
    .res_zero(res_zero), .res_neg(res_neg), .res_pred_taken(res_pred_taken),
    .branch_taken(branch_taken4), .mispredict(mispredict4),
    .br_count(br_count4), .mp_count(mp_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic set_res(input logic v, input logic [31:0] pc, input logic [1:0] mode,
                         input logic z, input logic n, input logic pt);
    res_valid = v; res_pc = pc; res_mode = mode;
    res_zero = z; res_neg = n; res_pred_taken = pt;
  endtask

  // Expected cond per mode for {zero,neg} = 00, 01, 10.
  logic exp_tab [4][3];
  logic [1:0] zn_tab [3];

  initial begin
    exp_tab[0][0] = 0; exp_tab[0][1] = 0; exp_tab[0][2] = 1; // BEQ
    exp_tab[1][0] = 1; exp_tab[1][1] = 1; exp_tab[1][2] = 0; // BNE
    exp_tab[2][0] = 0; exp_tab[2][1] = 1; exp_tab[2][2] = 1; // BLEZ
    exp_tab[3][0] = 1; exp_tab[3][1] = 0; exp_tab[3][2] = 0; // BGTZ
    zn_tab[0] = 2'b00; zn_tab[1] = 2'b01; zn_tab[2] = 2'b10;

    rst_n = 1'b0; lookup_valid = 1'b0; lookup_pc = '0;
    set_res(0, 32'h0, 2'b00, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;

    // 1: reset state and first lookup
    check("rst_pred_valid", pred_valid, 0);
    check("rst_mispredict", mispredict, 0);
    check("rst_br_count", br_count, 0);
    check("rst_mp_count", mp_count, 0);
    do_lookup(32'h40);
    check("t1_pred_valid", pred_valid, 1);
    check("t1_pred_taken", pred_taken, 0);
    tick();
    check("t1_pred_valid_drop", pred_valid, 0);

    // 2: condition table, resolve asserted only between edges
    for (int m = 0; m < 4; m++) begin
      for (int c = 0; c < 3; c++) begin
        set_res(1, 32'h100, m[1:0], zn_tab[c][1], zn_tab[c][0], 0);
        #1;
        check($sformatf("t2_cond_m%0d_zn%0d", m, c), branch_taken, exp_tab[m][c]);
        res_valid = 1'b0;
        #1;
        check($sformatf("t2_idle_m%0d_zn%0d", m, c), branch_taken, 0);
        tick();
      end
    end
    check("t2_no_stat_change", br_count, 0);

    // 3: training with two mispredicted taken BEQs
    set_res(1, 32'h40, 2'b00, 1, 0, 0);
    tick();
    check("t3_mp_pulse1", mispredict, 1);
    tick();
    check("t3_mp_pulse2", mispredict, 1);
    res_valid = 1'b0;
    tick();
    check("t3_mp_clear", mispredict, 0);
    do_lookup(32'h40);
    check("t3_pred_taken", pred_taken, 1);
    check("t3_br_count", br_count, 2);
    check("t3_mp_count", mp_count, 2);

    // 4: saturation at 11 then one not-taken step to 10
    set_res(1, 32'h40, 2'b00, 1, 0, 1);
    tick(); tick(); tick();
    check("t4_no_mispredict", mispredict, 0);
    set_res(1, 32'h40, 2'b00, 0, 0, 1);
    tick();
    check("t4_nt_mispredict", mispredict, 1);
    res_valid = 1'b0;
    do_lookup(32'h40);
    check("t4_pred_0x40", pred_taken, 1);
    do_lookup(32'h80);
    check("t4_pred_alias_0x80", pred_taken, 1);
    check("t4_br_count", br_count, 6);
    check("t4_mp_count", mp_count, 3);

    // 5: same-cycle lookup and not-taken resolve, entry at 10
    set_res(1, 32'h40, 2'b00, 0, 0, 1);
    do_lookup(32'h40);
    check("t5_pred_old", pred_taken, 1);
    check("t5_mispredict", mispredict, 1);
    res_valid = 1'b0;
    do_lookup(32'h40);
    check("t5_pred_new", pred_taken, 0);
    check("t5_br_count", br_count, 7);
    check("t5_mp_count", mp_count, 4);

    // 6: train idx 1 up, then reset with a resolve in flight
    set_res(1, 32'h44, 2'b00, 1, 0, 0);
    tick(); tick();
    rst_n = 1'b0;
    lookup_valid = 1'b1; lookup_pc = 32'h44;
    tick();
    rst_n = 1'b1; lookup_valid = 1'b0; res_valid = 1'b0;
    check("t6_rst_pred_valid", pred_valid, 0);
    check("t6_rst_mispredict", mispredict, 0);
    check("t6_rst_br_count", br_count, 0);
    check("t6_rst_mp_count", mp_count, 0);
    check("t6_rst_br_count4", br_count4, 0);
    for (int i = 0; i < 16; i++) begin
      do_lookup(32'(i * 4));
      check($sformatf("t6_init_idx%0d", i), pred_taken, 0);
    end
    // One taken step from CNT_INIT (01) reaches 10, so predict taken.
    set_res(1, 32'h48, 2'b00, 1, 0, 0);
    tick();
    res_valid = 1'b0;
    do_lookup(32'h48);
    check("t6_init_step", pred_taken, 1);

    // 20 mispredicted resolves: STAT_W=4 saturates at 15, STAT_W=16 does not
    set_res(1, 32'h4C, 2'b00, 1, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    res_valid = 1'b0;
    tick();
    check("t6_br_count4_sat", br_count4, 15);
    check("t6_mp_count4_sat", mp_count4, 15);
    check("t6_br_count16", br_count, 21);
    check("t6_mp_count16", mp_count, 21);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
